cordic_xyz_stage: RTL and testbench

Parametrised CORDIC micro-rotation stage that updates x, y and z together for circular, linear and hyperbolic modes, in both rotation and vectoring. Each stage has a valid/ready handshake and a registered output, so any number of stages can be chained into an elastic pipeline. In hyperbolic mode the stage can optionally run its iteration twice on its own, which provides the convergence repeats. This block replaces the per-coordinate, always-enabled x/y/z calculators in the CORDIC datapath.

---
 rtl/cordic_xyz_stage.sv | 198 +++++++++++++++++++
 tb/tb_cordic_xyz_stage.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_xyz_stage.sv
// cordic_xyz_stage: one CORDIC micro-rotation updating x, y and z together
// (circular / linear / hyperbolic, rotation or vectoring, mode 11 pass-through).
// Latency: 1 cycle; 2 cycles for hyperbolic transactions when HYP_REPEAT = 1.
// Backpressure: in_ready = 0 while the output is stalled or a repeat is in flight.
// Build option: define CORDIC_SAT_EN for saturating add/sub (default is W-bit wrap).
// Parameters: W (datapath width), SHIFT (iteration index), HYP_REPEAT (1 = run hyperbolic twice).
// Ports: clock, reset_n (async, active-low);
//        in_valid/in_ready/in_mode/in_vect/in_x/in_y/in_z/atan_val  - upstream handshake + operands;
//        out_valid/out_ready/out_x/out_y/out_z/out_mode/out_vect    - registered result + sideband.
module cordic_xyz_stage #(
   parameter int W          = 32,
   parameter int SHIFT      = 0,
   parameter int HYP_REPEAT = 0
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [1:0]   in_mode,
   input  logic         in_vect,
   input  logic [W-1:0] in_x,
   input  logic [W-1:0] in_y,
   input  logic [W-1:0] in_z,
   input  logic [W-1:0] atan_val,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_x,
   output logic [W-1:0] out_y,
   output logic [W-1:0] out_z,
   output logic [1:0]   out_mode,
   output logic         out_vect
);

   localparam logic [1:0] MODE_CIRC = 2'b00;
   localparam logic [1:0] MODE_LIN  = 2'b01;
   localparam logic [1:0] MODE_HYP  = 2'b10;
   localparam logic       REP_EN    = (HYP_REPEAT != 0);

   typedef struct packed {
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic [W-1:0] z;
   } xyz_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      REP  = 2'd2
   } state_t;

   // a + b (sub = 0) or a - b (sub = 1), two's complement.
   function automatic logic [W-1:0] addsub(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic         sub);
`ifdef CORDIC_SAT_EN
      logic [W:0] s;
      // One guard bit: the true result always fits in W+1 bits, so a
      // mismatch between the top two bits flags signed overflow.
      s = sub ? ({a[W-1], a} - {b[W-1], b}) : ({a[W-1], a} + {b[W-1], b});
      if (s[W] != s[W-1]) begin
         addsub = s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end else begin
         addsub = s[W-1:0];
      end
`else
      addsub = sub ? (a - b) : (a + b);
`endif
   endfunction

   // One micro-rotation. d_pos = 1 means d = +1.
   function automatic xyz_t do_pass(input logic [1:0]   mode,
                                    input logic         vect,
                                    input xyz_t         v,
                                    input logic [W-1:0] atan);
      xyz_t         r;
      logic [W-1:0] xs;
      logic [W-1:0] ys;
      logic         d_pos;
      xs    = $signed(v.x) >>> SHIFT;
      ys    = $signed(v.y) >>> SHIFT;
      d_pos = vect ? v.y[W-1] : ~v.z[W-1];
      r     = v;
      case (mode)
         MODE_CIRC: begin
            r.x = addsub(v.x, ys, d_pos);
            r.y = addsub(v.y, xs, ~d_pos);
            r.z = addsub(v.z, atan, d_pos);
         end
         MODE_LIN: begin
            r.y = addsub(v.y, xs, ~d_pos);
            r.z = addsub(v.z, atan, d_pos);
         end
         MODE_HYP: begin
            r.x = addsub(v.x, ys, ~d_pos);
            r.y = addsub(v.y, xs, ~d_pos);
            r.z = addsub(v.z, atan, d_pos);
         end
         default: r = v;
      endcase
      return r;
   endfunction

   state_t       state_q, state_d;
   xyz_t         out_q, out_d;
   logic [1:0]   omode_q, omode_d;
   logic         ovect_q, ovect_d;
   // Pass-1 result of a repeated hyperbolic transaction plus its sideband.
   xyz_t         rep_q, rep_d;
   logic [1:0]   rmode_q, rmode_d;
   logic         rvect_q, rvect_d;
   logic [W-1:0] ratan_q, ratan_d;

   xyz_t pass_in;
   xyz_t pass_rep;
   logic slot_free;
   logic accept;
   logic rep_start;

   assign pass_in   = do_pass(in_mode, in_vect, {in_x, in_y, in_z}, atan_val);
   assign pass_rep  = do_pass(rmode_q, rvect_q, rep_q, ratan_q);

   assign out_valid = (state_q == HOLD);
   assign slot_free = !out_valid || out_ready;
   assign in_ready  = (state_q != REP) && slot_free;
   assign accept    = in_valid && in_ready;
   assign rep_start = REP_EN && (in_mode == MODE_HYP);

   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      omode_d = omode_q;
      ovect_d = ovect_q;
      rep_d   = rep_q;
      rmode_d = rmode_q;
      rvect_d = rvect_q;
      ratan_d = ratan_q;
      case (state_q)
         IDLE, HOLD: begin
            if (accept) begin
               if (rep_start) begin
                  // In HOLD an accept implies out_ready, so the old result
                  // leaves this edge and the output slot is empty during REP.
                  rep_d   = pass_in;
                  rmode_d = in_mode;
                  rvect_d = in_vect;
                  ratan_d = atan_val;
                  state_d = REP;
               end else begin
                  out_d   = pass_in;
                  omode_d = in_mode;
                  ovect_d = in_vect;
                  state_d = HOLD;
               end
            end else if ((state_q == HOLD) && out_ready) begin
               state_d = IDLE;
            end
         end
         REP: begin
            if (slot_free) begin
               out_d   = pass_rep;
               omode_d = rmode_q;
               ovect_d = rvect_q;
               state_d = HOLD;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         out_q   <= '0;
         omode_q <= '0;
         ovect_q <= 1'b0;
         rep_q   <= '0;
         rmode_q <= '0;
         rvect_q <= 1'b0;
         ratan_q <= '0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         omode_q <= omode_d;
         ovect_q <= ovect_d;
         rep_q   <= rep_d;
         rmode_q <= rmode_d;
         rvect_q <= rvect_d;
         ratan_q <= ratan_d;
      end
   end

   assign out_x    = out_q.x;
   assign out_y    = out_q.y;
   assign out_z    = out_q.z;
   assign out_mode = omode_q;
   assign out_vect = ovect_q;

endmodule

// File: tb/tb_cordic_xyz_stage.sv
// Directed and randomized checks of cordic_xyz_stage at W = 16 using three instances:
// c (SHIFT=1, no repeat), h (SHIFT=4, HYP_REPEAT=1), l (SHIFT=0, no repeat).
module tb_cordic_xyz_stage;
   localparam int W = 16;
   localparam int N_RAND = 1000;
`ifdef CORDIC_SAT_EN
   localparam logic [15:0] LIN_Y = 16'h7FFF;
`else
   localparam logic [15:0] LIN_Y = 16'hFE00;
`endif

   logic clock = 1'b0;
   always #5 clock = ~clock;
   logic reset_n;

   int checks   = 0;
   int failures = 0;

   logic         c_iv, c_ir, c_vect, c_ov, c_or, c_ovect;
   logic [1:0]   c_mode, c_omode;
   logic [W-1:0] c_x, c_y, c_z, c_atan, c_ox, c_oy, c_oz;
   logic         h_iv, h_ir, h_vect, h_ov, h_or, h_ovect;
   logic [1:0]   h_mode, h_omode;
   logic [W-1:0] h_x, h_y, h_z, h_atan, h_ox, h_oy, h_oz;
   logic         l_iv, l_ir, l_vect, l_ov, l_or, l_ovect;
   logic [1:0]   l_mode, l_omode;
   logic [W-1:0] l_x, l_y, l_z, l_atan, l_ox, l_oy, l_oz;

   cordic_xyz_stage #(.W(W), .SHIFT(1), .HYP_REPEAT(0)) u_c (
      .clock(clock), .reset_n(reset_n), .in_valid(c_iv), .in_ready(c_ir),
      .in_mode(c_mode), .in_vect(c_vect), .in_x(c_x), .in_y(c_y), .in_z(c_z),
      .atan_val(c_atan), .out_valid(c_ov), .out_ready(c_or), .out_x(c_ox),
      .out_y(c_oy), .out_z(c_oz), .out_mode(c_omode), .out_vect(c_ovect));

   cordic_xyz_stage #(.W(W), .SHIFT(4), .HYP_REPEAT(1)) u_h (
      .clock(clock), .reset_n(reset_n), .in_valid(h_iv), .in_ready(h_ir),
      .in_mode(h_mode), .in_vect(h_vect), .in_x(h_x), .in_y(h_y), .in_z(h_z),
      .atan_val(h_atan), .out_valid(h_ov), .out_ready(h_or), .out_x(h_ox),
      .out_y(h_oy), .out_z(h_oz), .out_mode(h_omode), .out_vect(h_ovect));

   cordic_xyz_stage #(.W(W), .SHIFT(0), .HYP_REPEAT(0)) u_l (
      .clock(clock), .reset_n(reset_n), .in_valid(l_iv), .in_ready(l_ir),
      .in_mode(l_mode), .in_vect(l_vect), .in_x(l_x), .in_y(l_y), .in_z(l_z),
      .atan_val(l_atan), .out_valid(l_ov), .out_ready(l_or), .out_x(l_ox),
      .out_y(l_oy), .out_z(l_oz), .out_mode(l_omode), .out_vect(l_ovect));

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive_c(input logic [1:0] m, input logic v, input logic [15:0] x,
                          input logic [15:0] y, input logic [15:0] z, input logic [15:0] a);
      c_iv = 1'b1; c_mode = m; c_vect = v; c_x = x; c_y = y; c_z = z; c_atan = a;
   endtask

   task automatic drive_h(input logic [1:0] m, input logic v, input logic [15:0] x,
                          input logic [15:0] y, input logic [15:0] z, input logic [15:0] a);
      h_iv = 1'b1; h_mode = m; h_vect = v; h_x = x; h_y = y; h_z = z; h_atan = a;
   endtask

   // Reference arithmetic on plain integers, reduced to 16 bits at the end.
   function automatic logic [15:0] m_fix(input int v);
`ifdef CORDIC_SAT_EN
      if (v > 32767) return 16'h7FFF;
      if (v < -32768) return 16'h8000;
`endif
      return v[15:0];
   endfunction

   function automatic logic [47:0] m_step(input logic [1:0] mode, input logic vect,
                                          input logic [47:0] v, input logic [15:0] atan, input int sh);
      int x, y, z, a, d, xs, ys, nx, ny, nz;
      if (mode == 2'b11) return v;
      x  = int'($signed(v[47:32]));
      y  = int'($signed(v[31:16]));
      z  = int'($signed(v[15:0]));
      a  = int'($signed(atan));
      d  = vect ? ((y < 0) ? 1 : -1) : ((z >= 0) ? 1 : -1);
      xs = x >>> sh;
      ys = y >>> sh;
      nx = (mode == 2'b00) ? (x - d * ys) : (mode == 2'b10) ? (x + d * ys) : x;
      ny = y + d * xs;
      nz = z - d * a;
      return {m_fix(nx), m_fix(ny), m_fix(nz)};
   endfunction

   logic [50:0] sb_q[$];
   logic [50:0] sb_e;
   logic [47:0] e;
   int          sent, got, cyc;
   logic        took;

   initial begin
      reset_n = 1'b0;
      c_iv = 0; c_mode = 0; c_vect = 0; c_x = 0; c_y = 0; c_z = 0; c_atan = 0; c_or = 1;
      h_iv = 0; h_mode = 0; h_vect = 0; h_x = 0; h_y = 0; h_z = 0; h_atan = 0; h_or = 1;
      l_iv = 0; l_mode = 0; l_vect = 0; l_x = 0; l_y = 0; l_z = 0; l_atan = 0; l_or = 1;

      // Reset state
      @(negedge clock);
      @(negedge clock);
      check_val("rst_c_state", 64'({c_ov, c_omode, c_ovect, c_ox, c_oy, c_oz}), 64'd0);
      check_val("rst_h_state", 64'({h_ov, h_omode, h_ovect, h_ox, h_oy, h_oz}), 64'd0);
      reset_n = 1'b1;
      tick();
      @(negedge clock);
      check_val("rst_in_ready", 64'({c_ir, h_ir, l_ir}), 64'b111);

      // Circular rotation then circular vectoring, back-to-back
      tick();
      drive_c(2'b00, 1'b0, 16'h1000, 16'h0000, 16'h0100, 16'h0080);
      tick();
      drive_c(2'b00, 1'b1, 16'h1000, 16'h0400, 16'h0000, 16'h0080);
      @(negedge clock);
      check_val("circ_rot", 64'({c_ov, c_omode, c_ovect, c_ox, c_oy, c_oz}),
                64'({1'b1, 2'b00, 1'b0, 16'h1000, 16'h0800, 16'h0080}));
      tick();
      c_iv = 1'b0;
      @(negedge clock);
      check_val("circ_vect", 64'({c_ov, c_omode, c_ovect, c_ox, c_oy, c_oz}),
                64'({1'b1, 2'b00, 1'b1, 16'h1200, 16'hFC00, 16'h0080}));
      tick();
      @(negedge clock);
      check_val("circ_drain", 64'(c_ov), 64'd0);

      // Backpressure: A held 5 cycles while B waits, then back-to-back release
      tick();
      drive_c(2'b01, 1'b0, 16'h0100, 16'h0010, 16'h0000, 16'h0040);
      c_or = 1'b0;
      tick();
      drive_c(2'b10, 1'b0, 16'h1000, 16'h0000, 16'h0100, 16'h0100);
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         check_val("bp_hold", 64'({c_ov, c_omode, c_ovect, c_ox, c_oy, c_oz}),
                   64'({1'b1, 2'b01, 1'b0, 16'h0100, 16'h0090, 16'hFFC0}));
         check_val("bp_in_ready", 64'(c_ir), 64'd0);
         tick();
      end
      c_or = 1'b1;
      @(negedge clock);
      check_val("bp_release_rdy", 64'(c_ir), 64'd1);
      tick();
      c_iv = 1'b0;
      @(negedge clock);
      check_val("bp_b2b", 64'({c_ov, c_omode, c_ovect, c_ox, c_oy, c_oz}),
                64'({1'b1, 2'b10, 1'b0, 16'h1000, 16'h0800, 16'h0000}));
      tick();
      @(negedge clock);
      check_val("bp_drain", 64'(c_ov), 64'd0);

      // Hyperbolic rotation with repeat
      tick();
      drive_h(2'b10, 1'b0, 16'h2000, 16'h0000, 16'h0100, 16'h0010);
      @(negedge clock);
      check_val("hyp_acc_rdy", 64'(h_ir), 64'd1);
      tick();
      h_iv = 1'b0;
      @(negedge clock);
      check_val("hyp_rep_state", 64'({h_ov, h_ir}), 64'd0);
      tick();
      @(negedge clock);
      check_val("hyp_out", 64'({h_ov, h_omode, h_ovect, h_ox, h_oy, h_oz}),
                64'({1'b1, 2'b10, 1'b0, 16'h2020, 16'h0400, 16'h00E0}));
      check_val("hyp_rdy_after", 64'(h_ir), 64'd1);

      // Linear rotation at the positive overflow boundary
      tick();
      l_iv = 1'b1; l_mode = 2'b01; l_vect = 1'b0;
      l_x = 16'h7F00; l_y = 16'h7F00; l_z = 16'h0000; l_atan = 16'h0000;
      tick();
      l_iv = 1'b0;
      @(negedge clock);
      check_val("lin_ovf", 64'({l_ov, l_omode, l_ovect, l_ox, l_oy, l_oz}),
                64'({1'b1, 2'b01, 1'b0, 16'h7F00, LIN_Y, 16'h0000}));

      // Reset while c is stalled in HOLD and h is in REP
      tick();
      drive_c(2'b00, 1'b0, 16'h0400, 16'h0400, 16'h0000, 16'h0020);
      c_or = 1'b0;
      drive_h(2'b10, 1'b1, 16'h1234, 16'h0100, 16'h0000, 16'h0010);
      tick();
      c_iv = 1'b0;
      h_iv = 1'b0;
      @(negedge clock);
      check_val("pre_rst_rep", 64'({h_ov, h_ir}), 64'd0);
      check_val("pre_rst_hold", 64'(c_ov), 64'd1);
      #2 reset_n = 1'b0;
      #1;
      check_val("rst_hold_drop", 64'({c_ov, c_ox, c_oy, c_oz}), 64'd0);
      check_val("rst_rep_drop", 64'(h_ov), 64'd0);
      c_or = 1'b1;
      @(negedge clock);
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         @(negedge clock);
         check_val("rst_no_ghost", 64'({h_ov, c_ov, h_oz}), 64'd0);
      end

      // Random valid/ready traffic on the repeating instance against the model
      sent = 0; got = 0; cyc = 0; took = 1'b0;
      h_iv = 1'b0;
      while ((sent < N_RAND || sb_q.size() > 0) && cyc < 20000) begin
         tick();
         cyc++;
         if (took) h_iv = 1'b0;
         took = 1'b0;
         h_or = ($urandom_range(0, 3) != 0);
         if (!h_iv && sent < N_RAND && $urandom_range(0, 1) == 1) begin
            drive_h(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 16'($urandom),
                    16'($urandom), 16'($urandom), 16'($urandom_range(0, 16'h1000)));
         end
         @(negedge clock);
         if (h_ov && h_or) begin
            if (sb_q.size() == 0) begin
               check_val("rand_spurious", 64'd1, 64'd0);
            end else begin
               sb_e = sb_q.pop_front();
               check_val("rand_out", 64'({h_omode, h_ovect, h_ox, h_oy, h_oz}), 64'(sb_e));
               got++;
            end
         end
         if (h_iv && h_ir) begin
            e = m_step(h_mode, h_vect, {h_x, h_y, h_z}, h_atan, 4);
            if (h_mode == 2'b10) e = m_step(h_mode, h_vect, e, h_atan, 4);
            sb_q.push_back({h_mode, h_vect, e});
            sent++;
            took = 1'b1;
         end
      end
      h_iv = 1'b0;
      check_val("rand_count", 64'(got), 64'(N_RAND));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
